wb_packer: RTL and testbench
============================

# wb_packer

Write-back packer directly downstream of the compute engine. It accepts the engine's serial 16-bit result stream (`output_en` / `output_data`), packs consecutive results into PACK_LEN-lane words, and assigns each word a sequential output-RAM address. Packed words pass through a 2-entry queue to the output memory / pipe-out port. The engine cannot be stalled, so the packer never back-pressures it; a queue overrun is flagged instead.

## Interface
Parameters:
- `PACK_LEN`, 8, lanes per packed word; equals `BURST_LEN`.
- `ADDR_W`, 13, output word address width.

Ports:
- `clk`, in, 1, single clock for the block.
- `rst`, in, 1, reset; asynchronous, active-low.
- `layer_start`, in, 1, one-cycle pulse: clears the address and lane counters and empties the queue.
- `in_valid`, in, 1, engine `output_en`.
- `in_data`, in, 16, engine `output_data` (fp16).
- `flush`, in, 1, engine `gemm_finish`; emits a partial word.
- `out_valid`, in/out: out, 1, packed word available at queue head.
- `out_ready`, in, 1, consumer accepts the head word when `out_valid & out_ready`.
- `out_data`, out, 16*PACK_LEN, packed word; lane 0 in bits [15:0].
- `out_addr`, out, ADDR_W, word address of the head word.
- `lane_count`, out, 8, lanes filled in the word being built.
- `busy`, out, 1, high when `lane_count != 0` or the queue is non-empty.
- `overflow`, out, 1, sticky flag; set when a word is dropped. Cleared only by reset or `layer_start`.

## Operation
- Assembly register `acc` holds PACK_LEN lanes.
- On `in_valid`: `in_data` is written to lane `lane_count`.
  - If `lane_count == PACK_LEN-1`, the completed word is enqueued at `wr_addr`. `wr_addr` increments and `lane_count` returns to 0.
  - Otherwise `lane_count` increments.
- On `flush` with `lane_count > 0` (counting any lane written the same cycle): the partial word is enqueued with unfilled lanes zero, `wr_addr` increments, and `lane_count` returns to 0.
  - `flush` with nothing pending is a no-op.
- Simultaneous `in_valid` and `flush`: the datum is included first, then flushed. Exactly one word is enqueued.
- Queue:
  - 2 entries, each holding {data, addr}.
  - Head is presented on `out_*`.
  - Pop on `out_valid & out_ready`.
  - A push and a pop in the same cycle are both allowed when the queue is full.
  - A push when the queue is full and no pop occurs: the word is dropped, `overflow` is set, and `wr_addr` still increments, so later addresses stay correct.
- `wr_addr` wraps from 2^ADDR_W-1 to 0 silently.
- `layer_start` has priority over every other input that cycle:
  - partial lanes and queue contents are discarded;
  - `wr_addr` returns to 0;
  - `overflow` is cleared.
- Reset-mid-operation behaves identically to `layer_start`: all state is cleared asynchronously.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `lane_count`=0, `busy`=0, `overflow`=0.
- Latency: the word completed by the `in_valid` in cycle N (or by `flush` in cycle N) shows `out_valid`=1 in cycle N+1 when the queue was empty.
- `out_data` and `out_addr` are held stable while `out_valid & !out_ready`.
- `out_valid` never drops without a pop, except on `layer_start` or reset.
- Sustained throughput: one word per PACK_LEN `in_valid` cycles. With `out_ready` constantly high the queue never holds more than 1 entry.
- `overflow` rises in the cycle after the dropped push.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - an 8-bit idle counter runs while `lane_count > 0` and `in_valid` is low;
  - it resets on any `in_valid`;
  - when it reaches 255, an internal flush fires with the same effect as `flush`.
- `WB_TIMEOUT_EN` undefined: no counter. Partial words leave only via `flush`.

## Test plan
- 16 `in_valid` cycles with data 0x3C00+i, `out_ready`=1 -> two words at addr 0 and 1; word0 lane i = 0x3C00+i; `out_valid` appears 1 cycle after the 8th datum.
- 3 data, then `flush` -> one word at addr 0 with lanes 0–2 = data and lanes 3–7 = 0x0000; `lane_count` returns to 0. A second `flush` produces nothing.
- `out_ready`=0 while 24 data are streamed -> words 0 and 1 are queued, word 2 is dropped, `overflow`=1. After `out_ready`=1, addr 0 and 1 drain; the next word gets addr 3.
- `in_valid` and `flush` in the same cycle as the 5th datum -> a single word with 5 lanes filled; `wr_addr` advances by exactly 1.
- Preload `wr_addr` = 8191 via 8191 words, then 8 more data -> word emitted at 8191, the next at 0. Then `layer_start` mid-word -> `lane_count`=0, `out_valid`=0, next word at addr 0.
- (`WB_TIMEOUT_EN`) 2 data then 255 idle cycles -> partial word emitted; with the macro undefined, no word is emitted.

Source files
------------

// File: rtl/wb_packer.sv
// Write-back packer: gathers serial fp16 results into PACK_LEN-lane words and queues them with sequential addresses.
// Optional build macro WB_TIMEOUT_EN adds an idle-timeout flush of partial words.
module wb_packer #(
    parameter int PACK_LEN = 8,
    parameter int ADDR_W   = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     layer_start,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16*PACK_LEN-1:0]   out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [7:0]               lane_count,
    output logic                     busy,
    output logic                     overflow
);
    localparam int DATA_W = 16 * PACK_LEN;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic [DATA_W-1:0] acc_r;
    logic [7:0]        lane_count_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ENT_W-1:0]  q0_r, q1_r;
    logic [1:0]        q_cnt_r;
    logic              out_valid_r, busy_r, overflow_r;

    logic [DATA_W-1:0] word_s;
    logic [7:0]        filled_s, lane_nxt_s;
    logic              push_s, pop_s, drop_s, tmo_flush_s;
    logic [ENT_W-1:0]  push_ent_s, q0_nxt_s, q1_nxt_s;
    logic [1:0]        cnt_nxt_s;

`ifdef WB_TIMEOUT_EN
    logic [7:0] idle_cnt_r;

    // The 255th consecutive idle cycle with lanes pending acts as a flush.
    assign tmo_flush_s = (lane_count_r != 8'd0) && !in_valid && (idle_cnt_r == 8'd254);

    // Idle counter: restarts on any datum, on emission, or when nothing is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_r <= 8'd0;
        end else if (layer_start || in_valid || push_s || (lane_count_r == 8'd0)) begin
            idle_cnt_r <= 8'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 8'd1;
        end
    end
`else
    assign tmo_flush_s = 1'b0;
`endif

    // Word assembly and two-entry queue next-state; a same-cycle datum lands before a flush.
    always_comb begin
        word_s = acc_r;
        for (int i = 0; i < PACK_LEN; i++) begin
            if (in_valid && (lane_count_r == 8'(i))) begin
                word_s[16*i +: 16] = in_data;
            end else begin
                word_s[16*i +: 16] = acc_r[16*i +: 16];
            end
        end
        filled_s   = lane_count_r + {7'd0, in_valid};
        push_s     = (in_valid && (lane_count_r == 8'(PACK_LEN-1))) ||
                     ((flush || tmo_flush_s) && (filled_s != 8'd0));
        pop_s      = out_valid_r && out_ready;
        lane_nxt_s = push_s ? 8'd0 : filled_s;
        push_ent_s = {wr_addr_r, word_s};
        q0_nxt_s   = q0_r;
        q1_nxt_s   = q1_r;
        cnt_nxt_s  = q_cnt_r;
        drop_s     = 1'b0;
        case ({push_s, pop_s})
            2'b11: begin
                if (q_cnt_r == 2'd2) begin
                    q0_nxt_s = q1_r;
                    q1_nxt_s = push_ent_s;
                end else begin
                    q0_nxt_s = push_ent_s;
                end
            end
            2'b10: begin
                if (q_cnt_r == 2'd0) begin
                    q0_nxt_s  = push_ent_s;
                    cnt_nxt_s = 2'd1;
                end else if (q_cnt_r == 2'd1) begin
                    q1_nxt_s  = push_ent_s;
                    cnt_nxt_s = 2'd2;
                end else begin
                    drop_s = 1'b1;
                end
            end
            2'b01: begin
                q0_nxt_s  = q1_r;
                cnt_nxt_s = q_cnt_r - 2'd1;
            end
            default: begin
                q0_nxt_s = q0_r;
            end
        endcase
    end

    // State update; layer_start clears everything exactly like reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r        <= '0;
            lane_count_r <= 8'd0;
            wr_addr_r    <= '0;
            q0_r         <= '0;
            q1_r         <= '0;
            q_cnt_r      <= 2'd0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else if (layer_start) begin
            acc_r        <= '0;
            lane_count_r <= 8'd0;
            wr_addr_r    <= '0;
            q0_r         <= '0;
            q1_r         <= '0;
            q_cnt_r      <= 2'd0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            acc_r        <= push_s ? '0 : word_s;
            lane_count_r <= lane_nxt_s;
            wr_addr_r    <= push_s ? (wr_addr_r + ADDR_W'(1)) : wr_addr_r;
            q0_r         <= q0_nxt_s;
            q1_r         <= q1_nxt_s;
            q_cnt_r      <= cnt_nxt_s;
            out_valid_r  <= (cnt_nxt_s != 2'd0);
            busy_r       <= (lane_nxt_s != 8'd0) || (cnt_nxt_s != 2'd0);
            overflow_r   <= overflow_r || drop_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = q0_r[DATA_W-1:0];
    assign out_addr   = q0_r[ENT_W-1 -: ADDR_W];
    assign lane_count = lane_count_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
endmodule

// File: tb/tb_wb_packer.sv
// Bench for wb_packer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_wb_packer;
    localparam int PL = 8;
    localparam int AW = 13;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             layer_start = 1'b0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = 16'h0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [16*PL-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic [7:0]       lane_count;
    logic             busy;
    logic             overflow;

    wb_packer #(.PACK_LEN(PL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .in_valid(in_valid),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .lane_count(lane_count),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16*PL-1:0] data;
        int               addr;
    } ent_t;

    ent_t             m_q[$];
    logic [16*PL-1:0] m_word;
    int               m_lc;
    int               m_addr;
    bit               m_ovf;
`ifdef WB_TIMEOUT_EN
    int               m_idle;
`endif
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_word = '0;
        m_lc   = 0;
        m_addr = 0;
        m_ovf  = 1'b0;
`ifdef WB_TIMEOUT_EN
        m_idle = 0;
`endif
    endtask

    // One clock of the specification's rules, using the inputs held across this edge.
    task automatic model_step();
        bit pop, emit, tmo;
        if (!rst || layer_start) begin
            model_reset();
            return;
        end
        pop = (m_q.size() > 0) && out_ready;
        if (in_valid) begin
            m_word[16*m_lc +: 16] = in_data;
            m_lc++;
        end
        tmo = 1'b0;
`ifdef WB_TIMEOUT_EN
        if (!in_valid && m_lc > 0) begin
            m_idle++;
            tmo = (m_idle == 255);
        end else begin
            m_idle = 0;
        end
`endif
        emit = (m_lc == PL) || ((flush || tmo) && m_lc > 0);
        if (pop) void'(m_q.pop_front());
        if (emit) begin
            if (m_q.size() >= 2) m_ovf = 1'b1;
            else m_q.push_back('{m_word, m_addr});
            m_addr = (m_addr + 1) % (1 << AW);
            m_word = '0;
            m_lc   = 0;
`ifdef WB_TIMEOUT_EN
            m_idle = 0;
`endif
        end
    endtask

    task automatic step(input bit ls, input bit v, input logic [15:0] d, input bit fl, input bit rdy);
        layer_start = ls;
        in_valid    = v;
        in_data     = d;
        flush       = fl;
        out_ready   = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 128'(out_valid), 128'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("out_data", 128'(out_data), 128'(m_q[0].data));
                chk("out_addr", 128'(out_addr), 128'(m_q[0].addr));
            end
            chk("lane_count", 128'(lane_count), 128'(m_lc));
            chk("busy", 128'(busy), 128'((m_lc > 0) || (m_q.size() > 0)));
            chk("overflow", 128'(overflow), 128'(m_ovf));
        end
    end

    initial begin
        model_reset();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_addr", 128'(out_addr), 128'(0));
        chk("rst_lane_count", 128'(lane_count), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        rst = 1'b1;
        chk_en = 1'b1;

        // Two full words streamed with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 16'h3C00 + 16'(i), 1'b0, 1'b1);
            if (i == 6) chk("t1_no_early_valid", 128'(out_valid), 128'(0));
            if (i == 7) begin
                chk("t1_valid_after_8th", 128'(out_valid), 128'(1));
                chk("t1_w0_addr", 128'(out_addr), 128'(0));
                chk("t1_w0_lane0", 128'(out_data[15:0]), 128'(16'h3C00));
                chk("t1_w0_lane7", 128'(out_data[127:112]), 128'(16'h3C07));
            end
        end
        chk("t1_w1_addr", 128'(out_addr), 128'(1));
        chk("t1_w1_lane0", 128'(out_data[15:0]), 128'(16'h3C08));

        // Partial word via flush, then a flush with nothing pending.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0011 * 16'(i + 1), 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_partial_word", 128'(out_data), {80'h0, 16'h0033, 16'h0022, 16'h0011});
        chk("t2_partial_addr", 128'(out_addr), 128'(0));
        chk("t2_lane_reset", 128'(lane_count), 128'(0));
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_empty_flush_busy", 128'(busy), 128'(1));

        // Overrun with the consumer stalled.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 22) chk("t3_no_early_ovf", 128'(overflow), 128'(0));
        end
        chk("t3_overflow", 128'(overflow), 128'(1));
        chk("t3_head_held", 128'(out_addr), 128'(0));
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("t3_second_addr", 128'(out_addr), 128'(1));
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h7000 + 16'(i), 1'b0, 1'b1);
        chk("t3_after_drop_addr", 128'(out_addr), 128'(3));

        // Datum and flush together on the fifth lane.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0104, 1'b1, 1'b1);
        chk("t4_lane4", 128'(out_data[79:64]), 128'(16'h0104));
        chk("t4_lane5_zero", 128'(out_data[95:80]), 128'(0));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b1);
        chk("t4_next_addr", 128'(out_addr), 128'(1));

        // Address wrap, then layer_start mid-word.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8191; i++) step(1'b0, 1'b1, 16'(i), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h5500 + 16'(i), 1'b0, 1'b1);
        chk("t5_addr_top", 128'(out_addr), 128'(8191));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h5600 + 16'(i), 1'b0, 1'b1);
        chk("t5_addr_wrap", 128'(out_addr), 128'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        chk("t5_ls_lane", 128'(lane_count), 128'(0));
        chk("t5_ls_valid", 128'(out_valid), 128'(0));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h1200 + 16'(i), 1'b0, 1'b1);
        chk("t5_ls_next_addr", 128'(out_addr), 128'(0));

        // Idle timeout behaviour depends on the build.
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
`ifdef WB_TIMEOUT_EN
        chk("t6_tmo_emitted", 128'(out_valid), 128'(1));
        chk("t6_tmo_data", 128'(out_data[31:0]), 128'(32'hBBBBAAAA));
`else
        chk("t6_no_tmo_valid", 128'(out_valid), 128'(0));
        chk("t6_no_tmo_lanes", 128'(lane_count), 128'(2));
`endif

        // Randomized traffic with occasional layer_start and one reset mid-stream.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b0;
                model_reset();
                step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
                rst = 1'b1;
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 16'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
